// File: rtl/ram_ctrl_pkg.sv
// Shared encodings for the read-modify-write RAM controller: access sizes,
// FSM states, default RAM latency and the alignment check.
package ram_ctrl_pkg;

    localparam int unsigned RAM_LAT_DEF = 1;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_e;

    // Misaligned halfwords/words and the reserved size are rejected outright.
    function automatic logic access_err(input size_e size, input logic [1:0] lo);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = lo[0];
            SZ_WORD: err = (lo != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/ram_lane_unit.sv
// Little-endian byte-lane handling: merges store data into the fetched word
// and extracts/extends the addressed lanes for loads.
module ram_lane_unit
    import ram_ctrl_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign half_v = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        merged_o = rword_i;
        case (size_i)
            SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8]    = wdata_i[7:0];
            SZ_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merged_o = wdata_i;
        endcase
    end

    always_comb begin
        load_o = rword_i;
        case (size_i)
            SZ_BYTE: load_o = {{24{signed_i & byte_v[7]}}, byte_v};
            SZ_HALF: load_o = {{16{signed_i & half_v[15]}}, half_v};
            default: load_o = rword_i;
        endcase
    end

endmodule

// File: rtl/ram_rmw_ctrl.sv
// Single-port RAM controller: byte/halfword/word loads and stores, with
// sub-word stores done as read-modify-write over a RAM of latency RAM_LAT.
module ram_rmw_ctrl #(
    parameter int unsigned RAM_LAT = ram_ctrl_pkg::RAM_LAT_DEF,
    parameter int unsigned ADDR_W  = 7
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [31:0]       ram_dina,
    input  logic [31:0]       ram_douta
);
    import ram_ctrl_pkg::*;

    localparam int unsigned CNT_W = (RAM_LAT > 0) ? $clog2(RAM_LAT + 1) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, signed_q, err_q;
    size_e              size_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q, rword_q;
    logic               rd_last, accept, req_bad;
    logic [31:0]        merged, load_data;

    assign accept  = (state_q == S_IDLE) && req_valid;
    assign req_bad = access_err(size_e'(req_size), req_addr[1:0]);
    assign rd_last = (state_q == S_RD) && (cnt_q == CNT_W'(RAM_LAT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_d = '0;
                    if (req_bad)
                        state_d = S_RESP;
                    else if (req_we && size_e'(req_size) == SZ_WORD)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                if (rd_last)
                    state_d = we_q ? S_WR : S_RESP;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= SZ_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rword_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q     <= req_we;
                signed_q <= req_signed;
                err_q    <= req_bad;
                size_q   <= size_e'(req_size);
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (rd_last)
                rword_q <= ram_douta;
        end
    end

    ram_lane_unit u_lane (
        .size_i    (size_q),
        .addr_lo_i (addr_q[1:0]),
        .signed_i  (signed_q),
        .wdata_i   (wdata_q),
        .rword_i   (rword_q),
        .merged_o  (merged),
        .load_o    (load_data)
    );

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign resp_rdata = ((state_q == S_RESP) && !err_q && !we_q) ? load_data : '0;
    assign ram_wea    = (state_q == S_WR);
    assign ram_addra  = addr_q[ADDR_W+1:2];
    assign ram_dina   = (state_q == S_WR) ? merged : '0;

endmodule
